// File: rtl/dm_wb_cache_if.sv
// CPU-side and memory-side buses of the direct-mapped write-back cache.
// The CPU (bus adapter) masters the cache; the cache masters physical memory.

interface dm_wb_cache_if;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_byte_enable256;
    logic [255:0] mem_wdata256;
    logic [255:0] mem_rdata256;
    logic         mem_resp;

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable256, mem_wdata256,
        input  mem_rdata256, mem_resp
    );
    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable256, mem_wdata256,
        output mem_rdata256, mem_resp
    );
endinterface

interface dm_wb_cache_pmem_if;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    modport master (
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );
    modport slave (
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/dm_wb_cache.sv
// Direct-mapped, write-back, write-allocate cache with 256-bit lines.
// Hits complete combinationally in the request cycle; misses write back a
// dirty victim (if any), fill the line, then hit on the following cycle.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   CHECK     | idle / tag compare; hits answered here
//   WRITEBACK | dirty victim line being written to physical memory
//   ALLOCATE  | requested line being fetched from physical memory

module dm_wb_cache #(
    parameter int S_INDEX  = 4,
    parameter int S_OFFSET = 5,
    parameter int S_TAG    = 32 - S_OFFSET - S_INDEX
) (
    input  logic               clk,
    input  logic               rst,
    dm_wb_cache_if.slave       cpu,
    dm_wb_cache_pmem_if.master pmem
);
    localparam int NSETS = 2 ** S_INDEX;

    typedef enum logic [1:0] {CHECK, WRITEBACK, ALLOCATE} state_t;

    state_t             state, state_nxt;
    logic [NSETS-1:0]   valid, dirty;
    logic [S_TAG-1:0]   tags [NSETS];
    logic [255:0]       data [NSETS];

    logic [S_INDEX-1:0] idx;
    logic [S_TAG-1:0]   req_tag;
    logic               req, hit;
    logic               wr_hit, wb_done, fill;
    logic               resp_c, pread_c, pwrite_c;
    logic [31:0]        paddr_c;
    logic               unused_addr;

    assign idx         = cpu.mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
    assign req_tag     = cpu.mem_address[31:S_OFFSET+S_INDEX];
    assign req         = cpu.mem_read | cpu.mem_write;
    assign hit         = valid[idx] && (tags[idx] == req_tag);
    assign unused_addr = ^cpu.mem_address[S_OFFSET-1:0];

    assign cpu.mem_rdata256 = data[idx];
    assign cpu.mem_resp     = resp_c;
    assign pmem.pmem_wdata  = data[idx];
    assign pmem.pmem_read   = pread_c;
    assign pmem.pmem_write  = pwrite_c;
    assign pmem.pmem_address = paddr_c;

    // State register; reset returns to CHECK so all bus outputs drop at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CHECK;
        else     state <= state_nxt;
    end

    // Next state and bus outputs. A simultaneous read+write is a write
    // because only mem_write selects the store path.
    always_comb begin
        state_nxt = state;
        resp_c    = 1'b0;
        pread_c   = 1'b0;
        pwrite_c  = 1'b0;
        paddr_c   = 32'h0;
        wr_hit    = 1'b0;
        wb_done   = 1'b0;
        fill      = 1'b0;
        case (state)
            CHECK: begin
                if (req) begin
                    if (hit) begin
                        resp_c = 1'b1;
                        wr_hit = cpu.mem_write;
                    end else if (valid[idx] && dirty[idx]) begin
                        state_nxt = WRITEBACK;
                    end else begin
                        state_nxt = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pwrite_c = 1'b1;
                paddr_c  = {tags[idx], idx, {S_OFFSET{1'b0}}};
                if (pmem.pmem_resp) begin
                    wb_done   = 1'b1;
                    state_nxt = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pread_c = 1'b1;
                paddr_c = {cpu.mem_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
                if (pmem.pmem_resp) begin
                    fill      = 1'b1;
                    state_nxt = CHECK;
                end
            end
            default: state_nxt = CHECK;
        endcase
    end

    // Valid/dirty bookkeeping; these are the only array bits reset clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (wb_done) begin
            dirty[idx] <= 1'b0;
        end else if (wr_hit && (|cpu.mem_byte_enable256)) begin
            dirty[idx] <= 1'b1;
        end
    end

    // Line data and tags: filled from memory, or byte-merged on a write hit.
    always_ff @(posedge clk) begin
        if (fill) begin
            data[idx] <= pmem.pmem_rdata;
            tags[idx] <= req_tag;
        end else if (wr_hit) begin
            for (int i = 0; i < 32; i++) begin
                if (cpu.mem_byte_enable256[i])
                    data[idx][8*i +: 8] <= cpu.mem_wdata256[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dm_wb_cache.sv
// Testbench for dm_wb_cache: directed scenarios plus randomized traffic
// checked against a memory-view model (what the CPU must read back) and a
// per-set residency model that predicts hits, evictions and latency.

module tb_dm_wb_cache;
    logic clk = 1'b0;
    logic rst = 1'b1;

    dm_wb_cache_if      cpu_if();
    dm_wb_cache_pmem_if pm_if();

    dm_wb_cache dut (
        .clk  (clk),
        .rst  (rst),
        .cpu  (cpu_if),
        .pmem (pm_if)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int lat    = 3;
    int proto_err = 0;

    // physical memory contents and CPU-visible memory contents
    logic [255:0] pm [logic [31:0]];
    logic [255:0] rm [logic [31:0]];

    logic [31:0]  rd_log[$];
    logic [31:0]  wr_log_a[$];
    logic [255:0] wr_log_d[$];

    // residency model
    bit          mv [16];
    bit          md [16];
    logic [22:0] mt [16];

    function automatic logic [255:0] init_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++)
            l[32*w +: 32] = (la ^ 32'h5A5A_0000) + 32'(w) * 32'h0101_0101;
        return l;
    endfunction

    function automatic logic [255:0] pm_get(input logic [31:0] la);
        if (pm.exists(la)) return pm[la];
        return init_line(la);
    endfunction

    function automatic logic [255:0] rm_get(input logic [31:0] la);
        if (rm.exists(la)) return rm[la];
        return init_line(la);
    endfunction

    // physical memory: answers each request after lat cycles with a one-cycle resp
    initial begin : pmem_model
        int cnt;
        cnt = 0;
        pm_if.pmem_resp  = 1'b0;
        pm_if.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pm_if.pmem_resp = 1'b0;
            if (rst) begin
                cnt = 0;
            end else if (pm_if.pmem_read || pm_if.pmem_write) begin
                cnt++;
                if (cnt >= lat) begin
                    if (pm_if.pmem_write) begin
                        pm[pm_if.pmem_address] = pm_if.pmem_wdata;
                        wr_log_a.push_back(pm_if.pmem_address);
                        wr_log_d.push_back(pm_if.pmem_wdata);
                    end else begin
                        pm_if.pmem_rdata = pm_get(pm_if.pmem_address);
                        rd_log.push_back(pm_if.pmem_address);
                    end
                    pm_if.pmem_resp = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // memory-side protocol watcher; the result is checked in test_protocol
    always @(negedge clk) begin
        if (!rst) begin
            if (pm_if.pmem_read && pm_if.pmem_write) proto_err++;
            if ((pm_if.pmem_read || pm_if.pmem_write) && pm_if.pmem_address[4:0] != 5'd0) proto_err++;
            if (!pm_if.pmem_read && !pm_if.pmem_write && pm_if.pmem_address != 32'h0) proto_err++;
        end
    end

    task automatic cpu_access(input logic [31:0] a, input bit rd, input bit wr,
                              input logic [31:0] be, input logic [255:0] wd,
                              output logic [255:0] rdata, output int cyc);
        rd_log.delete();
        wr_log_a.delete();
        wr_log_d.delete();
        @(negedge clk);
        cpu_if.mem_address        = a;
        cpu_if.mem_byte_enable256 = be;
        cpu_if.mem_wdata256       = wd;
        cpu_if.mem_read           = rd;
        cpu_if.mem_write          = wr;
        cyc   = 0;
        rdata = 'x;
        forever begin
            #1;
            if (cpu_if.mem_resp === 1'b1) begin
                rdata = cpu_if.mem_rdata256;
                break;
            end
            if (cyc >= 200) break;
            cyc++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        cpu_if.mem_read  = 1'b0;
        cpu_if.mem_write = 1'b0;
    endtask

    // predicts one access from the cache's rules and updates the models
    task automatic model_access(input logic [31:0] a, input bit wr, input logic [31:0] be,
                                input logic [255:0] wd, output int e_cyc, output bit e_wb,
                                output logic [31:0] e_wba, output logic [255:0] e_wbd,
                                output bit e_fill, output logic [255:0] e_rd);
        int           idx;
        logic [22:0]  tg;
        logic [31:0]  la;
        logic [255:0] line;
        idx    = int'(a[8:5]);
        tg     = a[31:9];
        la     = {a[31:5], 5'b0};
        e_wb   = 1'b0;
        e_wba  = 32'h0;
        e_wbd  = '0;
        e_fill = 1'b0;
        e_cyc  = 0;
        if (!(mv[idx] && mt[idx] == tg)) begin
            e_fill = 1'b1;
            e_cyc  = lat + 1;
            if (mv[idx] && md[idx]) begin
                e_wb  = 1'b1;
                e_wba = {mt[idx], 4'(idx), 5'b0};
                e_wbd = rm_get(e_wba);
                e_cyc = 2 * lat + 1;
            end
            mv[idx] = 1'b1;
            md[idx] = 1'b0;
            mt[idx] = tg;
        end
        e_rd = rm_get(la);
        if (wr) begin
            line = e_rd;
            for (int b = 0; b < 32; b++)
                if (be[b]) line[8*b +: 8] = wd[8*b +: 8];
            rm[la] = line;
            if (be != 32'h0) md[idx] = 1'b1;
        end
    endtask

    // after reset every line is lost, so the CPU sees physical memory again
    task automatic model_reset();
        rm.delete();
        foreach (pm[k]) rm[k] = pm[k];
        for (int i = 0; i < 16; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
    endtask

    logic [255:0] r_data, e_rd, e_wbd, l1, l1_mod;
    logic [31:0]  e_wba;
    int           cyc, e_cyc;
    bit           e_wb, e_fill;

    task automatic test_reset();
        cpu_if.mem_address        = 32'h0;
        cpu_if.mem_read           = 1'b0;
        cpu_if.mem_write          = 1'b0;
        cpu_if.mem_byte_enable256 = 32'h0;
        cpu_if.mem_wdata256       = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (pm_if.pmem_read !== 1'b0 || pm_if.pmem_write !== 1'b0 || cpu_if.mem_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd=%b wr=%b resp=%b want 0 0 0",
                     pm_if.pmem_read, pm_if.pmem_write, cpu_if.mem_resp);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (pm_if.pmem_address !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_paddr: got %h want 0", pm_if.pmem_address);
        end
        model_reset();
    endtask

    task automatic test_read_miss();
        lat = 3;
        l1  = init_line(32'h40);
        model_access(32'h40, 1'b0, 32'h0, '0, e_cyc, e_wb, e_wba, e_wbd, e_fill, e_rd);
        cpu_access(32'h40, 1'b1, 1'b0, 32'h0, '0, r_data, cyc);
        n_cmp++;
        if (cyc !== 4) begin n_fail++; $display("FAIL miss_latency: got %0d want 4", cyc); end
        n_cmp++;
        if (rd_log.size() != 1 || wr_log_a.size() != 0) begin
            n_fail++;
            $display("FAIL miss_pmem_ops: got rd=%0d wr=%0d want 1 0", rd_log.size(), wr_log_a.size());
        end
        if (rd_log.size() > 0) begin
            n_cmp++;
            if (rd_log[0] !== 32'h40) begin n_fail++; $display("FAIL miss_paddr: got %h want 00000040", rd_log[0]); end
        end
        n_cmp++;
        if (r_data !== l1) begin n_fail++; $display("FAIL miss_rdata: got %h want %h", r_data, l1); end
    endtask

    task automatic test_read_hit();
        model_access(32'h44, 1'b0, 32'h0, '0, e_cyc, e_wb, e_wba, e_wbd, e_fill, e_rd);
        cpu_access(32'h44, 1'b1, 1'b0, 32'h0, '0, r_data, cyc);
        n_cmp++;
        if (cyc !== 0 || rd_log.size() != 0 || wr_log_a.size() != 0) begin
            n_fail++;
            $display("FAIL hit_latency: got cyc=%0d rd=%0d wr=%0d want 0 0 0", cyc, rd_log.size(), wr_log_a.size());
        end
        n_cmp++;
        if (r_data !== l1) begin n_fail++; $display("FAIL hit_rdata: got %h want %h", r_data, l1); end
    endtask

    task automatic test_write_hit();
        logic [255:0] wd;
        wd = {8{32'hDEADBEEF}};
        l1_mod = l1;
        l1_mod[63:32] = 32'hDEADBEEF;
        model_access(32'h44, 1'b1, 32'h0000_00F0, wd, e_cyc, e_wb, e_wba, e_wbd, e_fill, e_rd);
        cpu_access(32'h44, 1'b0, 1'b1, 32'h0000_00F0, wd, r_data, cyc);
        n_cmp++;
        if (cyc !== 0) begin n_fail++; $display("FAIL write_hit_latency: got %0d want 0", cyc); end
        model_access(32'h48, 1'b0, 32'h0, '0, e_cyc, e_wb, e_wba, e_wbd, e_fill, e_rd);
        cpu_access(32'h48, 1'b1, 1'b0, 32'h0, '0, r_data, cyc);
        n_cmp++;
        if (r_data !== l1_mod) begin n_fail++; $display("FAIL write_merge: got %h want %h", r_data, l1_mod); end
    endtask

    task automatic test_dirty_evict();
        model_access(32'h240, 1'b0, 32'h0, '0, e_cyc, e_wb, e_wba, e_wbd, e_fill, e_rd);
        cpu_access(32'h240, 1'b1, 1'b0, 32'h0, '0, r_data, cyc);
        n_cmp++;
        if (cyc !== 7) begin n_fail++; $display("FAIL evict_latency: got %0d want 7", cyc); end
        n_cmp++;
        if (wr_log_a.size() != 1 || rd_log.size() != 1) begin
            n_fail++;
            $display("FAIL evict_pmem_ops: got wr=%0d rd=%0d want 1 1", wr_log_a.size(), rd_log.size());
        end
        if (wr_log_a.size() > 0) begin
            n_cmp++;
            if (wr_log_a[0] !== 32'h40 || wr_log_d[0] !== l1_mod) begin
                n_fail++;
                $display("FAIL evict_wb: got %h/%h want 00000040/%h", wr_log_a[0], wr_log_d[0], l1_mod);
            end
        end
        if (rd_log.size() > 0) begin
            n_cmp++;
            if (rd_log[0] !== 32'h240) begin n_fail++; $display("FAIL evict_fill_addr: got %h want 00000240", rd_log[0]); end
        end
        n_cmp++;
        if (r_data !== init_line(32'h240)) begin
            n_fail++;
            $display("FAIL evict_rdata: got %h want %h", r_data, init_line(32'h240));
        end
    endtask

    task automatic test_clean_evict();
        model_access(32'h440, 1'b0, 32'h0, '0, e_cyc, e_wb, e_wba, e_wbd, e_fill, e_rd);
        cpu_access(32'h440, 1'b1, 1'b0, 32'h0, '0, r_data, cyc);
        n_cmp++;
        if (cyc !== 4 || wr_log_a.size() != 0 || rd_log.size() != 1) begin
            n_fail++;
            $display("FAIL clean_evict: got cyc=%0d wr=%0d rd=%0d want 4 0 1", cyc, wr_log_a.size(), rd_log.size());
        end
        if (rd_log.size() > 0) begin
            n_cmp++;
            if (rd_log[0] !== 32'h440) begin n_fail++; $display("FAIL clean_fill_addr: got %h want 00000440", rd_log[0]); end
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0]  a, be;
        logic [255:0] wd;
        bit           rd, wr;
        int           op;
        for (int k = 0; k < n; k++) begin
            lat = int'($urandom_range(1, 4));
            a   = {23'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31))};
            op  = int'($urandom_range(0, 3));
            rd  = (op != 2);
            wr  = (op >= 2);
            be  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            for (int w = 0; w < 8; w++) wd[32*w +: 32] = $urandom;
            model_access(a, wr, be, wd, e_cyc, e_wb, e_wba, e_wbd, e_fill, e_rd);
            cpu_access(a, rd, wr, be, wd, r_data, cyc);
            n_cmp++;
            if (cyc !== e_cyc) begin n_fail++; $display("FAIL rand_latency[%0d] a=%h: got %0d want %0d", k, a, cyc, e_cyc); end
            n_cmp++;
            if (r_data !== e_rd) begin n_fail++; $display("FAIL rand_rdata[%0d] a=%h: got %h want %h", k, a, r_data, e_rd); end
            n_cmp++;
            if (wr_log_a.size() != int'(e_wb) || rd_log.size() != int'(e_fill)) begin
                n_fail++;
                $display("FAIL rand_pmem_ops[%0d]: got wr=%0d rd=%0d want %0d %0d", k, wr_log_a.size(), rd_log.size(), e_wb, e_fill);
            end
            if (e_wb && wr_log_a.size() > 0) begin
                n_cmp++;
                if (wr_log_a[0] !== e_wba || wr_log_d[0] !== e_wbd) begin
                    n_fail++;
                    $display("FAIL rand_wb[%0d]: got %h/%h want %h/%h", k, wr_log_a[0], wr_log_d[0], e_wba, e_wbd);
                end
            end
            if (e_fill && rd_log.size() > 0) begin
                n_cmp++;
                if (rd_log[0] !== {a[31:5], 5'b0}) begin
                    n_fail++;
                    $display("FAIL rand_fill_addr[%0d]: got %h want %h", k, rd_log[0], {a[31:5], 5'b0});
                end
            end
        end
    endtask

    task automatic test_reset_mid_alloc();
        bit seen;
        lat  = 10;
        seen = 1'b0;
        rd_log.delete();
        @(negedge clk);
        cpu_if.mem_address = 32'h640;
        cpu_if.mem_read    = 1'b1;
        cpu_if.mem_write   = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (pm_if.pmem_read === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || pm_if.pmem_address !== 32'h640) begin
            n_fail++;
            $display("FAIL alloc_start: got seen=%b addr=%h want 1 00000640", seen, pm_if.pmem_address);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (pm_if.pmem_read !== 1'b0 || pm_if.pmem_write !== 1'b0 || pm_if.pmem_address !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_drop: got rd=%b wr=%b addr=%h want 0 0 0",
                     pm_if.pmem_read, pm_if.pmem_write, pm_if.pmem_address);
        end
        cpu_if.mem_read = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        lat = 3;
        foreach (rd_log[i]) begin end
        model_access(32'h640, 1'b0, 32'h0, '0, e_cyc, e_wb, e_wba, e_wbd, e_fill, e_rd);
        cpu_access(32'h640, 1'b1, 1'b0, 32'h0, '0, r_data, cyc);
        n_cmp++;
        if (cyc !== 4 || rd_log.size() != 1 || wr_log_a.size() != 0) begin
            n_fail++;
            $display("FAIL refetch_after_reset: got cyc=%0d rd=%0d wr=%0d want 4 1 0", cyc, rd_log.size(), wr_log_a.size());
        end
        n_cmp++;
        if (r_data !== init_line(32'h640)) begin
            n_fail++;
            $display("FAIL refetch_rdata: got %h want %h", r_data, init_line(32'h640));
        end
    endtask

    task automatic test_protocol();
        n_cmp++;
        if (proto_err !== 0) begin n_fail++; $display("FAIL pmem_protocol: got %0d violations want 0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_dirty_evict();
        test_clean_evict();
        test_random(60);
        test_reset_mid_alloc();
        test_random(30);
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
